edge_trigger: RTL and testbench
===============================

EDGE_TRIGGER -- requirements
Module: edge_trigger

Interface
REQ-001 SHALL have parameter TYPE, default 1, meaning detected polarity: 0 = falling edge, 1 = rising edge, 2 = either edge; any other value SHALL behave as 1.
REQ-002 SHALL have parameter WIDTH, default 1, meaning number of independent detector channels (1..32).
REQ-003 SHALL have port CLK  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port nRESET  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port IN  input  WIDTH  monitored levels, one bit per channel.
REQ-006 SHALL have port En  input  1  sample/acknowledge enable, common to all channels.
REQ-007 SHALL have port EDGE  output  WIDTH  per-channel edge indication, combinational.

Function
REQ-008 SHALL hold one reference register PREV[i] per channel.
REQ-009 SHALL load PREV[i] <= S[i] at a rising CLK edge only when nRESET=1 and En=1; PREV SHALL hold otherwise. S is the detection input defined in REQ-017/018.
REQ-010 SHALL drive EDGE[i] = S[i] & ~PREV[i] for TYPE=1, ~S[i] & PREV[i] for TYPE=0, and S[i] ^ PREV[i] for TYPE=2.
REQ-011 EDGE SHALL be combinational from S and PREV, with zero added register latency: it asserts in the same cycle S differs from PREV.
REQ-012 Pending edge: while En=0, an edge SHALL keep EDGE asserted for as long as S keeps its new level, and the edge SHALL NOT be lost.
REQ-013 An edge pulse followed by a return to the old level while En=0 SHALL produce no indication. Indication is level-vs-reference, not event-counting.
REQ-014 On a cycle with En=1 and EDGE[i]=1, the edge SHALL be consumed: from the next cycle EDGE[i]=0 unless S[i] changes again.
REQ-015 With En held at 1, each qualifying transition of S SHALL produce EDGE high for exactly one CLK cycle.
REQ-016 Channels SHALL be fully independent; simultaneous edges on several channels SHALL each be reported.

Configuration
REQ-017 With macro EDGE_TRIGGER_SYNC_EN defined, each IN bit SHALL pass through a two-flop synchronizer clocked every CLK, not gated by En and not reset. S is the second-stage output, so EDGE appears 2 cycles after the IN change.
REQ-018 Without EDGE_TRIGGER_SYNC_EN, S SHALL equal IN directly. There is no synchronizer and no added latency.

Reset
REQ-019 While nRESET=0, EDGE SHALL be all zeros.
REQ-020 While nRESET=0, PREV SHALL load S on every rising CLK edge regardless of En.
REQ-021 If the input is stable through reset, no edge SHALL be reported on the first cycle after reset.
REQ-022 A reset asserted while an edge is pending SHALL discard that edge.
REQ-023 An IN change that occurs while nRESET=0 SHALL NOT be reported after release.

Verification
REQ-024 Rising-edge case: TYPE=1, WIDTH=1, En=1, IN 0->1 at cycle 5 -> EDGE=1 in cycle 5 only (cycle 7 with SYNC_EN); EDGE=0 when IN later returns to 0.
REQ-025 Falling-edge case: TYPE=0, En=1, IN 1->0 -> one-cycle EDGE=1; rising IN -> EDGE stays 0.
REQ-026 Pending case: TYPE=1, En=0, IN 0->1 at cycle 3 -> EDGE=1 continuously. En=1 at cycle 10 -> EDGE=1 in cycle 10, 0 from cycle 11.
REQ-027 Cancelled-glitch case: TYPE=1, En=0, IN 0->1->0 across cycles 3-5, then En=1 -> EDGE never asserts after cycle 5.
REQ-028 Both-edges multi-channel case: TYPE=2, WIDTH=4, En=1, IN 4'b0000->4'b0101->4'b0100 -> EDGE=4'b0101 for one cycle, then 4'b0001 for one cycle.
REQ-029 Reset case: nRESET=0 for 3 cycles, with IN 0->1 during reset and En=0 -> EDGE=0 during reset and after release.

Source files
------------

// File: rtl/edge_trigger.sv
// edge_trigger -- per-channel edge detector with a hold-until-acknowledged
// reference register.
//
// Each channel keeps a reference PREV of its detection input S. EDGE is the
// combinational difference between S and PREV for the selected polarity. The
// reference only advances when En is high, so an edge stays visible until it
// is acknowledged. A pulse that goes away again before the acknowledge leaves
// no indication.
//
// Parameters:
//   TYPE  : 0 = falling, 1 = rising, 2 = either edge (other values act as 1)
//   WIDTH : number of independent channels (1..32)
// Ports:
//   CLK    in          clock, rising edge
//   nRESET in          synchronous active-low reset
//   IN     in  [WIDTH] monitored levels
//   En     in          sample / acknowledge enable, shared by all channels
//   EDGE   out [WIDTH] per-channel edge indication, combinational
// Configuration:
//   EDGE_TRIGGER_SYNC_EN : when defined, each IN bit first passes through a
//   two-flop synchronizer. This adds two cycles of latency.

module edge_trigger_lane #(
  parameter int TYPE = 1
) (
  input  logic CLK,
  input  logic nRESET,
  input  logic s,
  input  logic en,
  output logic hit
);
  logic prev;
  logic det;

  // During reset the reference tracks S on every edge. Any change seen while
  // in reset is absorbed, and nothing is reported after release.
  always_ff @(posedge CLK)
    if (!nRESET || en) prev <= s;

  always_comb begin
    det = s & ~prev;
    case (TYPE)
      0:       det = ~s & prev;
      2:       det = s ^ prev;
      default: det = s & ~prev;
    endcase
  end

  assign hit = nRESET & det;
endmodule

module edge_trigger #(
  parameter int TYPE  = 1,
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             nRESET,
  input  logic [WIDTH-1:0] IN,
  input  logic             En,
  output logic [WIDTH-1:0] EDGE
);
  logic [WIDTH-1:0] s;

`ifdef EDGE_TRIGGER_SYNC_EN
  // Plain two-flop synchronizer. It runs every cycle and has no reset, so it
  // keeps tracking IN regardless of En.
  logic [WIDTH-1:0] sync_q1;
  logic [WIDTH-1:0] sync_q2;

  always_ff @(posedge CLK) begin
    sync_q1 <= IN;
    sync_q2 <= sync_q1;
  end

  assign s = sync_q2;
`else
  assign s = IN;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    edge_trigger_lane #(.TYPE(TYPE)) u_lane (
      .CLK    (CLK),
      .nRESET (nRESET),
      .s      (s[i]),
      .en     (En),
      .hit    (EDGE[i])
    );
  end
endmodule

// File: tb/tb_edge_trigger.sv
// Directed bench for edge_trigger, default build (no synchronizer).
// Four instances share CLK, nRESET and En:
//   u_rise (TYPE=1), u_fall (TYPE=0), u_both (TYPE=2, WIDTH=4),
//   u_odd (TYPE=5, which must behave as rising).
// Inputs change 1 time unit after a rising edge. EDGE is checked 1 time unit
// later, inside the same cycle.

module tb_edge_trigger;
  logic       CLK = 1'b0;
  logic       nRESET;
  logic       En;
  logic       in_r, in_f, in_o;
  logic [3:0] in_b;
  logic       e_r, e_f, e_o;
  logic [3:0] e_b;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  edge_trigger #(.TYPE(1), .WIDTH(1)) u_rise (
    .CLK(CLK), .nRESET(nRESET), .IN(in_r), .En(En), .EDGE(e_r));
  edge_trigger #(.TYPE(0), .WIDTH(1)) u_fall (
    .CLK(CLK), .nRESET(nRESET), .IN(in_f), .En(En), .EDGE(e_f));
  edge_trigger #(.TYPE(2), .WIDTH(4)) u_both (
    .CLK(CLK), .nRESET(nRESET), .IN(in_b), .En(En), .EDGE(e_b));
  edge_trigger #(.TYPE(5), .WIDTH(1)) u_odd (
    .CLK(CLK), .nRESET(nRESET), .IN(in_o), .En(En), .EDGE(e_o));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  initial begin
    nRESET = 1'b0; En = 1'b0;
    in_r = 1'b0; in_f = 1'b0; in_o = 1'b0; in_b = 4'h0;
    tick(); tick();
    settle();
    chk("rst_r", 32'(e_r), 32'h0);
    chk("rst_b", 32'(e_b), 32'h0);

    // Inputs change while reset is held: EDGE stays gated low
    in_r = 1'b1; in_f = 1'b1; in_o = 1'b1; in_b = 4'hF;
    settle();
    chk("rst_chg_r", 32'(e_r), 32'h0);
    chk("rst_chg_o", 32'(e_o), 32'h0);
    chk("rst_chg_b", 32'(e_b), 32'h0);
    tick();
    nRESET = 1'b1;
    settle();
    // A change made during reset must not be reported after release
    chk("post_rst_r", 32'(e_r), 32'h0);
    chk("post_rst_o", 32'(e_o), 32'h0);
    chk("post_rst_b", 32'(e_b), 32'h0);
    tick();
    chk("post_rst2_r", 32'(e_r), 32'h0);

    // Falling transitions, En=1
    En = 1'b1;
    in_r = 1'b0; in_f = 1'b0; in_o = 1'b0; in_b = 4'h0;
    settle();
    chk("fall_r", 32'(e_r), 32'h0);
    chk("fall_f", 32'(e_f), 32'h1);
    chk("fall_o", 32'(e_o), 32'h0);
    chk("fall_b", 32'(e_b), 32'hF);
    tick();
    chk("fall_cons_f", 32'(e_f), 32'h0);
    chk("fall_cons_b", 32'(e_b), 32'h0);

    // Rising transitions, En=1: exactly one cycle high
    in_r = 1'b1; in_f = 1'b1; in_o = 1'b1;
    settle();
    chk("rise_r", 32'(e_r), 32'h1);
    chk("rise_f", 32'(e_f), 32'h0);
    chk("rise_o", 32'(e_o), 32'h1);
    tick();
    chk("rise_cons_r", 32'(e_r), 32'h0);
    chk("rise_cons_o", 32'(e_o), 32'h0);
    in_r = 1'b0; in_f = 1'b0; in_o = 1'b0;
    settle();
    chk("ret_r", 32'(e_r), 32'h0);
    chk("ret_f", 32'(e_f), 32'h1);
    tick();
    chk("ret_cons_f", 32'(e_f), 32'h0);

    // Both-edge, multi-channel
    in_b = 4'b0101;
    settle();
    chk("both_1", 32'(e_b), 32'h5);
    tick();
    in_b = 4'b0100;
    settle();
    chk("both_2", 32'(e_b), 32'h1);
    tick();
    chk("both_3", 32'(e_b), 32'h0);

    // Pending edge held while En=0, consumed on the cycle En returns
    En = 1'b0;
    in_r = 1'b1;
    settle();
    chk("pend_0", 32'(e_r), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("pend_hold", 32'(e_r), 32'h1);
    end
    En = 1'b1;
    settle();
    chk("pend_ack", 32'(e_r), 32'h1);
    tick();
    chk("pend_done", 32'(e_r), 32'h0);

    // Glitch cancelled while En=0
    in_r = 1'b0;
    tick();
    En = 1'b0;
    in_r = 1'b1;
    settle();
    chk("gl_up", 32'(e_r), 32'h1);
    tick();
    in_r = 1'b0;
    settle();
    chk("gl_down", 32'(e_r), 32'h0);
    tick();
    En = 1'b1;
    settle();
    chk("gl_en", 32'(e_r), 32'h0);
    tick();
    chk("gl_after", 32'(e_r), 32'h0);

    // Reset discards a pending edge
    En = 1'b0;
    in_r = 1'b1;
    settle();
    chk("rd_pend", 32'(e_r), 32'h1);
    tick();
    nRESET = 1'b0;
    settle();
    chk("rd_in_rst", 32'(e_r), 32'h0);
    tick();
    nRESET = 1'b1;
    settle();
    chk("rd_release", 32'(e_r), 32'h0);
    tick();
    chk("rd_after", 32'(e_r), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
